pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage RV32I pipeline.

---
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush scheduler for the 5-stage RV32I pipeline (load-use,
//               EX redirects, multi-cycle data memory) with debug counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_pcsrc,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                c_WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic [CNT_W-1:0]    r_flush_count;

  logic w_load_use;
  logic w_mem_stall;

  assign w_load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
  assign w_mem_stall = mem_req && !mem_ready;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    if (rst || (r_state == ST_ERR)) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (w_mem_stall) begin
      // EX is held here, so a pending redirect is acted on in the release cycle
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_pcsrc) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= c_WAIT_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready || !mem_req) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_state   <= ST_ERR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_ERR: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_en && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (if_id_flush && !(&r_flush_count)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_pcsrc, mem_req, mem_ready;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_err;
  int          m_run;
  longint      m_stall, m_flush;
  localparam longint c_SAT = (64'd1 << CNT_W) - 1;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_pcsrc(ex_pcsrc),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  function automatic logic [6:0] outs();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};
  endfunction

  function automatic logic [6:0] model_outs();
    bit lu, ms;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    ms = mem_req && !mem_ready;
    if (rst || m_err) return 7'b0000000;
    if (ms)           return 7'b0000001;
    if (ex_pcsrc)     return 7'b1111110;
    if (lu)           return 7'b0001110;
    return 7'b1101010;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit lr, input int rd, input int rs1, input bit u1,
                        input int rs2, input bit u2, input bit pcs, input bit req, input bit rdy);
    rst = r; ex_mem_read = lr; ex_rd = 5'(rd); id_rs1 = 5'(rs1); id_use_rs1 = u1;
    id_rs2 = 5'(rs2); id_use_rs2 = u2; ex_pcsrc = pcs; mem_req = req; mem_ready = rdy;
  endtask

  // Called just after a posedge: check combinational outputs, clock, check registers.
  task automatic cycle();
    logic [6:0] e;
    #2;
    e = model_outs();
    chk("enables", longint'(outs()), longint'(e));
    @(posedge clk);
    if (rst) begin
      m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[6] && m_stall != c_SAT) m_stall++;
      if (e[4] && m_flush != c_SAT) m_flush++;
      if (!m_err) begin
        if (mem_req && !mem_ready) begin
          m_run++;
          if (m_run >= MEM_TIMEOUT) m_err = 1;
        end else begin
          m_run = 0;
        end
      end
    end
    #1;
    chk("mem_err", longint'(mem_err), longint'(m_err));
    chk("stall_cycles", longint'(stall_cycles), m_stall);
    chk("flush_count", longint'(flush_count), m_flush);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("reset_outs", longint'(outs()), 64'h0);
    cycle();
    idle();
  endtask

  initial begin
    m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();
    chk("reset_stall", longint'(stall_cycles), 0);
    chk("reset_flush", longint'(flush_count), 0);
    chk("reset_err", longint'(mem_err), 0);

    // T1 load-use: single bubble
    set_in(0, 1, 5, 5, 1, 0, 0, 0, 0, 0);
    #2 chk("t1_outs", longint'(outs()), 64'b0001110);
    cycle();
    chk("t1_stall", longint'(stall_cycles), 1);
    idle();
    #2 chk("t1_after", longint'(outs()), 64'b1101010);
    cycle();

    // T2 load to x0 is never a hazard; rs2 path also exercised
    set_in(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    #2 chk("t2_outs", longint'(outs()), 64'b1101010);
    cycle();
    set_in(0, 1, 9, 3, 0, 9, 1, 0, 0, 0);
    #2 chk("t2_rs2", longint'(outs()), 64'b0001110);
    cycle();

    // T3 redirect wins over load-use
    do_reset();
    set_in(0, 1, 5, 5, 1, 0, 0, 1, 0, 0);
    #2 chk("t3_outs", longint'(outs()), 64'b1111110);
    cycle();
    chk("t3_flush", longint'(flush_count), 1);
    chk("t3_stall", longint'(stall_cycles), 0);

    // T4 three wait cycles then release
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #2 chk("t4_wait", longint'(outs()), 64'b0000001);
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #2 chk("t4_release", longint'(outs()), 64'b1101010);
    cycle();
    chk("t4_stall", longint'(stall_cycles), 3);
    idle();
    cycle();

    // T5 timeout
    do_reset();
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
      chk("t5_err", longint'(mem_err), (i == MEM_TIMEOUT) ? 1 : 0);
    end
    idle();
    #2 chk("t5_frozen", longint'(outs()), 64'b0000000);
    cycle();
    cycle();
    chk("t5_sticky", longint'(mem_err), 1);

    // T6 redirect held through a 2-cycle stall
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      #2 chk("t6_wait", longint'(outs()), 64'b0000001);
      cycle();
    end
    chk("t6_noflush", longint'(flush_count), 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    #2 chk("t6_release", longint'(outs()), 64'b1111110);
    cycle();
    chk("t6_flush", longint'(flush_count), 1);
    // reset mid-stall must clear the wait count
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
    end
    do_reset();
    chk("t6_rst_stall", longint'(stall_cycles), 0);
    chk("t6_rst_flush", longint'(flush_count), 0);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
    end
    chk("t6_no_err", longint'(mem_err), 0);

    // randomized traffic, alternating fast and slow memory phases
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit slow;
      slow = ((n / 250) % 2) == 1;
      set_in($urandom_range(0, 79) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 4) == 0,
             slow ? 1'b1 : ($urandom_range(0, 2) == 0),
             slow ? ($urandom_range(0, 20) == 0) : ($urandom_range(0, 1) == 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
